// File: rtl/coef_out.sv
// coef_out: captures an N x W coefficient frame in parallel and streams it out one beat per handshake.
// Optional macro COEF_OUT_CHECKSUM_EN appends a final XOR-checksum beat to every frame.
module coef_out #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         din [N-1:0],
    output logic [W-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [$clog2(N)-1:0] dout_idx,
    output logic                 dout_last
);
    localparam int unsigned   IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef COEF_OUT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CKSUM} state_t;
`else
    typedef enum logic {IDLE, STREAM} state_t;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_inc;
    logic [W-1:0]  buf_q [N-1:0];
    logic [W-1:0]  buf_d [N-1:0];
    logic [W-1:0]  dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic [IW-1:0] dout_idx_q, dout_idx_d;
    logic          dout_last_q, dout_last_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_done;

`ifdef COEF_OUT_CHECKSUM_EN
    logic [W-1:0]  cksum_c;

    always_comb begin
        cksum_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            cksum_c = cksum_c ^ buf_q[i];
        end
    end
`endif

    // Next-state and next-output logic; outputs are precomputed so they leave the block from flops.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_idx_d   = dout_idx_q;
        dout_last_d  = dout_last_q;
        in_ready_d   = in_ready_q;
        frame_done   = 1'b0;
        idx_inc      = idx_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d        = din;
                    state_d      = STREAM;
                    idx_d        = '0;
                    dout_d       = din[0];
                    dout_valid_d = 1'b1;
                    dout_idx_d   = '0;
                    dout_last_d  = 1'b0;
                    in_ready_d   = 1'b0;
                end
            end
            STREAM: begin
                if (dout_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef COEF_OUT_CHECKSUM_EN
                        state_d     = CKSUM;
                        idx_d       = '0;
                        dout_d      = cksum_c;
                        dout_idx_d  = '0;
                        dout_last_d = 1'b1;
`else
                        frame_done  = 1'b1;
`endif
                    end else begin
                        idx_d      = idx_inc;
                        dout_d     = buf_q[idx_inc];
                        dout_idx_d = idx_inc;
`ifdef COEF_OUT_CHECKSUM_EN
                        dout_last_d = 1'b0;
`else
                        dout_last_d = (idx_inc == LAST_IDX);
`endif
                    end
                end
            end
`ifdef COEF_OUT_CHECKSUM_EN
            CKSUM: begin
                if (dout_ready) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        // Final handshake of a frame: drop back to IDLE with quiet outputs.
        if (frame_done) begin
            state_d      = IDLE;
            idx_d        = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            dout_idx_d   = '0;
            dout_last_d  = 1'b0;
            in_ready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            for (int i = 0; i < int'(N); i++) begin
                buf_q[i] <= '0;
            end
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_idx_q   <= '0;
            dout_last_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_idx_q   <= dout_idx_d;
            dout_last_q  <= dout_last_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_idx   = dout_idx_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_coef_out.sv
// Testbench for coef_out: directed and randomized frames checked against a frame-level reference model.
module tb_coef_out;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;
`ifdef COEF_OUT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [W-1:0] frame_t [N-1:0];
    typedef struct packed {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  din [N-1:0];
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [IW-1:0] dout_idx;
    logic          dout_last;

    int    tests;
    int    fails;
    beat_t obs[$];
    beat_t exp_q[$];
    int    stall_err;
    int    cyc;
    bit    timed_out;

    coef_out #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the beats a frame must produce, straight from the frame contents.
    task automatic build_exp(input frame_t f);
        logic [W-1:0] x;
        exp_q.delete();
        x = '0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({f[i], IW'(i), (i == N - 1) && !CK});
            x = x ^ f[i];
        end
        if (CK) exp_q.push_back({x, IW'(0), 1'b1});
    endtask

    task automatic accept(input frame_t f);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        din      = f;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Records handshaked beats until the block goes idle; mode 0 ready high, 1 toggling, 2 random.
    task automatic collect(input int mode);
        beat_t b, prev;
        bit    stalled;
        obs.delete();
        stall_err = 0;
        timed_out = 1'b0;
        stalled   = 1'b0;
        prev      = '0;
        cyc       = 0;
        for (int c = 0; c < 400; c++) begin
            if (!dout_valid) begin
                if (obs.size() > 0) begin
                    cyc = c;
                    return;
                end
            end else begin
                b = {dout, dout_idx, dout_last};
                if (stalled && b != prev) stall_err++;
                case (mode)
                    0:       dout_ready = 1'b1;
                    1:       dout_ready = (c % 2 == 0);
                    default: dout_ready = 1'($urandom_range(0, 1));
                endcase
                if (dout_ready) obs.push_back(b);
                prev    = b;
                stalled = !dout_ready;
            end
            @(negedge clk);
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        frame_t f;
        rst_n = 1'b1; in_valid = 1'b0; dout_ready = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, dout_valid, dout, dout_idx, dout_last} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b d=%h idx=%0d last=%b", in_ready, dout_valid, dout, dout_idx, dout_last);
        end
        in_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hold: got vld=%b rdy=%b expected 0 1", dout_valid, in_ready);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        accept(f);
        collect(0);
        build_exp(f);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL reset_first_frame_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL reset_first_frame_beat%0d: got %h expected %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_basic();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = 8'(i);
        accept(f);
        collect(0);
        build_exp(f);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_beat%0d: got d=%h idx=%0d last=%b expected d=%h idx=%0d last=%b",
                         i, obs[i].d, obs[i].i, obs[i].l, exp_q[i].d, exp_q[i].i, exp_q[i].l);
            end
        end
        tests++;
        if (cyc != N + int'(CK)) begin
            fails++;
            $display("FAIL basic_throughput: got %0d cycles expected %0d", cyc, N + int'(CK));
        end
        tests++;
        if ({in_ready, dout, dout_last} !== {1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL basic_idle_after: got rdy=%b d=%h last=%b expected 1 00 0", in_ready, dout, dout_last);
        end
    endtask

    task automatic test_backpressure();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = 8'(i);
        accept(f);
        collect(1);
        build_exp(f);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL bp_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL bp_beat%0d: got %h expected %h", i, obs[i], exp_q[i]);
            end
        end
        tests++;
        if (stall_err != 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d changes during stall expected 0", stall_err);
        end
    endtask

    task automatic test_in_valid_hold();
        frame_t f, ff;
        for (int i = 0; i < N; i++) begin
            f[i]  = 8'($urandom);
            ff[i] = 8'hFF;
        end
        accept(f);
        din = ff;
        in_valid = 1'b1;
        collect(0);
        build_exp(f);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL hold_first_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL hold_first_beat%0d: got %h expected %h", i, obs[i], exp_q[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        collect(0);
        build_exp(ff);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL hold_ff_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL hold_ff_beat%0d: got %h expected %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_midframe_reset();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        accept(f);
        dout_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (dout_valid !== 1'b1 || dout_idx !== 3'd4) begin
            fails++;
            $display("FAIL midrst_pre: got vld=%b idx=%0d expected 1 4", dout_valid, dout_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({dout_valid, in_ready, dout, dout_idx, dout_last} !== {1'b0, 1'b1, 8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL midrst_async: got vld=%b rdy=%b d=%h idx=%0d last=%b", dout_valid, in_ready, dout, dout_idx, dout_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (dout_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_no_partial: got vld=%b rdy=%b expected 0 1", dout_valid, in_ready);
        end
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        accept(f);
        collect(0);
        build_exp(f);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL midrst_next_count: got %0d beats expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL midrst_next_beat%0d: got %h expected %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_patterns();
        frame_t f;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) f[i] = (p == 0) ? 8'hA5 : 8'(8'h11 * i);
            accept(f);
            collect(0);
            build_exp(f);
            tests++;
            if (timed_out || obs.size() != exp_q.size()) begin
                fails++;
                $display("FAIL pattern%0d_count: got %0d beats expected %0d", p, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs.size()) begin
                tests++;
                if (obs[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL pattern%0d_beat%0d: got %h expected %h", p, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        frame_t f;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) f[i] = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(f);
            collect(int'($urandom_range(0, 2)));
            build_exp(f);
            tests++;
            if (timed_out || obs.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d beats expected %0d", k, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs.size()) begin
                tests++;
                if (obs[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d: got %h expected %h", k, i, obs[i], exp_q[i]);
                end
            end
            tests++;
            if (stall_err != 0) begin
                fails++;
                $display("FAIL rand%0d_stable: got %0d changes during stall expected 0", k, stall_err);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_in_valid_hold();
        test_midframe_reset();
        test_patterns();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
